dec3_8_pulse: RTL

Registered 3-to-8 decoder with a valid/ready code input and timed one-hot output pulses. It is the receive-side counterpart of the 8-to-3 encoder (`en8_3`). Each accepted 3-bit code drives the matching bit of `y` for a programmable number of cycles, followed by an optional idle gap. It is gated by an active-high `enb`, matching the encoder's enable sense.

---
 rtl/dec3_8_pkg.sv | 12 +
 rtl/onehot3_8.sv | 9 +
 rtl/dec3_8_pulse.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dec3_8_pkg.sv
// Shared types and constants for the pulsed 3-to-8 decoder.
package dec3_8_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GAP
    } state_e;

endpackage

// File: rtl/onehot3_8.sv
// Combinational 3-bit binary to 8-bit one-hot decode.
module onehot3_8 (
    input  logic [2:0] in,
    output logic [7:0] out
);

    assign out = 8'b0000_0001 << in;

endmodule

// File: rtl/dec3_8_pulse.sv
// Registered 3-to-8 decoder: each accepted code drives its one-hot bit of y
// for PULSE_LEN cycles, then holds off for GAP_LEN idle cycles.
module dec3_8_pulse
    import dec3_8_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enb,
    input  logic [2:0] code,
    input  logic       code_valid,
    output logic       code_ready,
    output logic [7:0] y,
    output logic       busy,
    output logic       done,
    output logic       abort,
    output logic [7:0] acc_cnt
);

    localparam int               PULSE_LOAD_I = (PULSE_LEN > 0) ? PULSE_LEN - 1 : 0;
    localparam int               GAP_LOAD_I   = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;
    localparam logic [CNT_W-1:0] PULSE_LOAD   = PULSE_LOAD_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] GAP_LOAD     = GAP_LOAD_I[CNT_W-1:0];
    localparam bit               GAP_EN       = GAP_LEN > 0;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       code_q, code_d;
    logic [7:0]       y_q, y_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
    logic [7:0]       acc_q, acc_d;

    logic [2:0] dec_in;
    logic [7:0] dec_out;
    logic       accept;

    // One decoder serves both the accept edge (fresh code) and the held pulse.
    assign dec_in = (state_q == IDLE) ? code : code_q;

    onehot3_8 u_onehot (
        .in  (dec_in),
        .out (dec_out)
    );

    assign code_ready = (state_q == IDLE) && enb;
    assign accept     = code_ready && code_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        y_d     = y_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                y_d = 8'b0;
                if (accept) begin
                    code_d  = code;
                    y_d     = dec_out;
                    cnt_d   = PULSE_LOAD;
                    acc_d   = acc_q + 8'd1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                // Losing enable wins over a pulse that is just finishing.
                if (!enb) begin
                    y_d     = 8'b0;
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    y_d    = 8'b0;
                    done_d = 1'b1;
                    if (GAP_EN) begin
                        cnt_d   = GAP_LOAD;
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    y_d   = dec_out;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                y_d = 8'b0;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                y_d     = 8'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= 3'd0;
            y_q     <= 8'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            acc_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            y_q     <= y_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            acc_q   <= acc_d;
        end
    end

    assign y       = y_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign abort   = abort_q;
    assign acc_cnt = acc_q;

endmodule
